// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core.
// Fetch-queue entry and default depth live here next to the bus types.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;
    typedef logic [31:0] instruction_t;

    typedef struct packed {
        bus32_t       pc;
        instruction_t instr;
    } fetch_entry_t;

    localparam int IFQ_DEPTH = 4;

endpackage

// File: rtl/ifq_fifo.sv
// Show-ahead FIFO of fetch entries with synchronous flush.
// Head reads as zero when the FIFO is empty.
module ifq_fifo
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   push_i,
    input  fetch_entry_t           data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = pop_i && (r_count != '0);
    assign w_push = push_i && (w_pop || (r_count != FULL));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= data_i;
    end

    assign data_o  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign count_o = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential PC generation, credit-limited
// memory requests, stale-response discard on redirect, show-ahead output.
module ifetch_queue
    import tartaruga_pkg::*;
#(
    parameter int     DEPTH    = IFQ_DEPTH,
    parameter bus32_t RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         taken_branch_i,
    input  bus32_t       new_pc_i,
    output logic         imem_req_valid_o,
    input  logic         imem_req_ready_i,
    output bus32_t       imem_req_addr_o,
    input  logic         imem_rsp_valid_i,
    input  instruction_t imem_rsp_data_i,
    output logic         instr_valid_o,
    input  logic         instr_ready_i,
    output bus32_t       pc_o,
    output instruction_t instr_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW+1:0] LIMIT = (CW + 2)'(DEPTH);

    bus32_t        r_fetch_pc;
    bus32_t        r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_count;
    logic [CW+1:0] w_credits;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_rsp_take;
    logic          w_rsp_any;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Every slot is reserved from request until pop or discard.
    assign w_credits = (CW + 2)'(w_count)
                     + (CW + 2)'(r_outstanding)
                     + (CW + 2)'(r_discard);

    assign imem_req_valid_o = rstn_i && !taken_branch_i && (w_credits < LIMIT);
    assign imem_req_addr_o  = rstn_i ? r_fetch_pc : '0;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    assign w_rsp_drop = imem_rsp_valid_i && (r_discard != '0);
    assign w_rsp_take = imem_rsp_valid_i && (r_discard == '0)
                     && (r_outstanding != '0);
    assign w_rsp_any  = w_rsp_drop || w_rsp_take;
    assign w_push     = w_rsp_take && !taken_branch_i;

    assign instr_valid_o = (w_count != '0) && !taken_branch_i;
    assign w_pop         = instr_valid_o && instr_ready_i;

    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data_i};
    assign pc_o         = w_head.pc;
    assign instr_o      = w_head.instr;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .flush_i (taken_branch_i),
        .data_o  (w_head),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (taken_branch_i) begin
            // In-flight requests become discards; a same-cycle response is one of them.
            r_fetch_pc    <= new_pc_i;
            r_rsp_pc      <= new_pc_i;
            r_outstanding <= '0;
            r_discard     <= r_discard + r_outstanding - CW'(w_rsp_any);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp_take) r_rsp_pc <= r_rsp_pc + 32'd4;
            if (w_rsp_drop) r_discard <= r_discard - CW'(1);
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
        end
    end

    a_rsp_expected: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        imem_rsp_valid_i |-> ((r_outstanding != '0) || (r_discard != '0))
    );

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        w_count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: memory model plus in-order scoreboard.
// A second instance with a wrapping reset PC shadows the first.
module tb_ifetch_queue;
    import tartaruga_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] new_pc = '0;
    logic        mem_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        dec_ready = 1'b0;

    logic        rv1, iv1, rv2, iv2;
    bus32_t      addr1, pc1, addr2, pc2;
    logic [31:0] instr1, instr2;

    int checks = 0;
    int errors = 0;

    mreq_t       mq[$];
    sb_t         sb[$];
    int          n_buf = 0;
    logic [31:0] exp_fetch = '0;
    int          lat = 1;
    int          cyc = 0;

    logic        s_rv, s_iv, s_fire, s_pop, s_rv2, s_iv2;
    logic [31:0] s_addr, s_pc, s_instr, s_addr2, s_pc2;
    int          s_cyc;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .taken_branch_i   (taken),
        .new_pc_i         (new_pc),
        .imem_req_valid_o (rv1),
        .imem_req_ready_i (mem_ready),
        .imem_req_addr_o  (addr1),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (iv1),
        .instr_ready_i    (dec_ready),
        .pc_o             (pc1),
        .instr_o          (instr1)
    );

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .taken_branch_i   (taken),
        .new_pc_i         (new_pc),
        .imem_req_valid_o (rv2),
        .imem_req_ready_i (mem_ready),
        .imem_req_addr_o  (addr2),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (iv2),
        .instr_ready_i    (dec_ready),
        .pc_o             (pc2),
        .instr_o          (instr2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic tick();
        int    stale_n;
        bit    exp_rv, exp_iv, fire_m, pop_m;
        mreq_t m;
        stale_n = 0;
        #4;
        foreach (mq[i]) if (mq[i].stale) stale_n++;
        exp_rv = !taken && ((sb.size() + stale_n) < 4);
        exp_iv = (n_buf != 0) && !taken;
        s_cyc = cyc;
        s_rv = rv1; s_addr = addr1; s_iv = iv1;
        s_pc = pc1; s_instr = instr1;
        s_rv2 = rv2; s_addr2 = addr2; s_iv2 = iv2; s_pc2 = pc2;
        s_fire = rv1 && mem_ready;
        s_pop = iv1 && dec_ready;
        checks++;
        if (rv1 !== exp_rv)
            $display("FAIL credit cyc=%0d got %b want %b", cyc, rv1, exp_rv);
        checks++;
        if (iv1 !== exp_iv)
            $display("FAIL instr_valid cyc=%0d got %b want %b", cyc, iv1, exp_iv);
        if (rv1 !== exp_rv || iv1 !== exp_iv) errors++;
        if (exp_iv) begin
            checks++;
            if (pc1 !== sb[0].pc || instr1 !== sb[0].instr) begin
                errors++;
                $display("FAIL head cyc=%0d got %h/%h want %h/%h",
                         cyc, pc1, instr1, sb[0].pc, sb[0].instr);
            end
        end else if (n_buf == 0) begin
            checks++;
            if (pc1 !== 32'h0 || instr1 !== 32'h0) begin
                errors++;
                $display("FAIL empty_zero cyc=%0d got %h/%h want 0/0",
                         cyc, pc1, instr1);
            end
        end
        fire_m = exp_rv && mem_ready;
        if (fire_m) begin
            checks++;
            if (addr1 !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr cyc=%0d got %h want %h", cyc, addr1, exp_fetch);
            end
        end
        pop_m = exp_iv && dec_ready;
        @(posedge clk);
        #1;
        if (rsp_valid && mq.size() != 0) begin
            m = mq.pop_front();
            if (!m.stale && !taken) n_buf++;
        end
        if (pop_m) begin
            void'(sb.pop_front());
            n_buf--;
        end
        if (taken) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            sb.delete();
            n_buf = 0;
            exp_fetch = new_pc;
        end else if (fire_m) begin
            mq.push_back('{addr: exp_fetch, data: mem_word(exp_fetch),
                           due: cyc + lat, stale: 1'b0});
            sb.push_back('{pc: exp_fetch, instr: mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
        end
        cyc++;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data = mq[0].data;
        end else begin
            rsp_valid = 1'b0;
            rsp_data = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        taken = 1'b0;
        new_pc = '0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        mem_ready = 1'b0;
        dec_ready = 1'b0;
        mq.delete();
        sb.delete();
        n_buf = 0;
        exp_fetch = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b0 || addr1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_req got %b/%h want 0/0", rv1, addr1);
        end
        checks++;
        if (iv1 !== 1'b0 || pc1 !== 32'h0 || instr1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got %b/%h/%h want 0/0/0", iv1, pc1, instr1);
        end
        checks++;
        if (rv2 !== 1'b0 || addr2 !== 32'h0 || iv2 !== 1'b0 || pc2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_wrap got %b/%h/%b/%h want 0", rv2, addr2, iv2, pc2);
        end
        do_reset();
        mem_ready = 1'b1;
        tick();
        checks++;
        if (s_rv !== 1'b1 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got %b/%h want 1/0", s_rv, s_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (s_fire !== 1'b1 || s_addr !== 32'(s_cyc * 4)) begin
                errors++;
                $display("FAIL stream_req cyc=%0d got %b/%h want 1/%h",
                         s_cyc, s_fire, s_addr, 32'(s_cyc * 4));
            end
            if (s_cyc >= 2) begin
                checks++;
                if (s_iv !== 1'b1 || s_pc !== 32'((s_cyc - 2) * 4)) begin
                    errors++;
                    $display("FAIL stream_out cyc=%0d got %b/%h want 1/%h",
                             s_cyc, s_iv, s_pc, 32'((s_cyc - 2) * 4));
                end
            end
        end
    endtask

    task automatic test_full();
        int fires, pops;
        do_reset();
        lat = 1;
        mem_ready = 1'b1;
        dec_ready = 1'b0;
        fires = 0;
        repeat (10) begin
            tick();
            if (s_fire) fires++;
        end
        checks++;
        if (fires != 4 || s_rv !== 1'b0 || s_iv !== 1'b1 || s_pc !== 32'h0) begin
            errors++;
            $display("FAIL full got fires=%0d rv=%b iv=%b pc=%h want 4/0/1/0",
                     fires, s_rv, s_iv, s_pc);
        end
        dec_ready = 1'b1;
        fires = 0;
        pops = 0;
        repeat (6) begin
            tick();
            if (s_fire) fires++;
            if (s_pop) pops++;
        end
        checks++;
        if (pops < 4 || fires < 1) begin
            errors++;
            $display("FAIL full_drain got pops=%0d fires=%0d want >=4/>=1", pops, fires);
        end
    endtask

    task automatic test_redirect();
        int          fires, first;
        logic [31:0] fpc, finstr;
        do_reset();
        lat = 3;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        fires = 0;
        repeat (2) begin
            tick();
            if (s_fire) fires++;
        end
        mem_ready = 1'b0;
        taken = 1'b1;
        new_pc = 32'h100;
        tick();
        checks++;
        if (fires != 2 || s_iv !== 1'b0 || s_rv !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle got fires=%0d iv=%b rv=%b want 2/0/0",
                     fires, s_iv, s_rv);
        end
        taken = 1'b0;
        mem_ready = 1'b1;
        first = -1;
        fpc = '0;
        finstr = '0;
        for (int i = 0; i < 20 && first < 0; i++) begin
            tick();
            if (s_iv) begin
                first = s_cyc;
                fpc = s_pc;
                finstr = s_instr;
            end
        end
        checks++;
        if (first != 7 || fpc !== 32'h100 || finstr !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL redirect_first got cyc=%0d pc=%h instr=%h want 7/100/%h",
                     first, fpc, finstr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_collide();
        int          first;
        logic [31:0] fpc;
        do_reset();
        lat = 1;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        repeat (4) tick();
        taken = 1'b1;
        new_pc = 32'h100;
        tick();
        checks++;
        if (s_iv !== 1'b0 || s_rv !== 1'b0 || s_pop !== 1'b0) begin
            errors++;
            $display("FAIL collide_cycle got iv=%b rv=%b pop=%b want 0/0/0",
                     s_iv, s_rv, s_pop);
        end
        taken = 1'b0;
        tick();
        checks++;
        if (s_fire !== 1'b1 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL collide_next got %b/%h want 1/100", s_fire, s_addr);
        end
        first = -1;
        fpc = '0;
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick();
            if (s_pop) begin
                first = s_cyc;
                fpc = s_pc;
            end
        end
        checks++;
        if (first != 7 || fpc !== 32'h100) begin
            errors++;
            $display("FAIL collide_first got cyc=%0d pc=%h want 7/100", first, fpc);
        end
    endtask

    task automatic test_stall_random();
        int          fires, pops;
        bit          held;
        logic [31:0] held_addr;
        do_reset();
        lat = 1;
        fires = 0;
        pops = 0;
        held = 1'b0;
        held_addr = '0;
        for (int i = 0; i < 2000 && fires < 50; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            dec_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (held) begin
                checks++;
                if (s_rv !== 1'b1 || s_addr !== held_addr) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got %b/%h want 1/%h",
                             s_cyc, s_rv, s_addr, held_addr);
                end
            end
            held = s_rv && !mem_ready;
            held_addr = s_addr;
            if (s_fire) fires++;
            if (s_pop) pops++;
        end
        checks++;
        if (fires != 50) begin
            errors++;
            $display("FAIL stall_fires got %0d want 50", fires);
        end
        mem_ready = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 40 && pops < 50; i++) begin
            tick();
            if (s_pop) pops++;
        end
        checks++;
        if (pops != 50 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got pops=%0d left=%0d want 50/0", pops, sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want_a [3];
        want_a[0] = 32'hFFFF_FFF8;
        want_a[1] = 32'hFFFF_FFFC;
        want_a[2] = 32'h0000_0000;
        do_reset();
        lat = 1;
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_addr2 !== want_a[i] || s_rv2 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_addr cyc=%0d got %b/%h want 1/%h",
                         s_cyc, s_rv2, s_addr2, want_a[i]);
            end
        end
        checks++;
        if (s_iv2 !== 1'b1 || s_pc2 !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_out0 got %b/%h want 1/fffffff8", s_iv2, s_pc2);
        end
        repeat (2) tick();
        checks++;
        if (s_iv2 !== 1'b1 || s_pc2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out2 got %b/%h want 1/0", s_iv2, s_pc2);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (rv1 !== 1'b0 || addr1 !== 32'h0 || iv1 !== 1'b0 ||
            pc1 !== 32'h0 || instr1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got %b/%h/%b/%h/%h want 0",
                     rv1, addr1, iv1, pc1, instr1);
        end
        checks++;
        if (rv2 !== 1'b0 || addr2 !== 32'h0 || iv2 !== 1'b0 ||
            pc2 !== 32'h0 || instr2 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_wrap got %b/%h/%b/%h/%h want 0",
                     rv2, addr2, iv2, pc2, instr2);
        end
        do_reset();
        mem_ready = 1'b1;
        dec_ready = 1'b1;
        tick();
        checks++;
        if (s_addr !== 32'h0 || s_addr2 !== 32'hFFFF_FFF8 || s_rv2 !== 1'b1) begin
            errors++;
            $display("FAIL restart got %h/%h/%b want 0/fffffff8/1",
                     s_addr, s_addr2, s_rv2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_collide();
        test_stall_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
